// File: rtl/aes_dec_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | aes_dec_pkg                                                                |
// | Shared types and constants for the AES-256 decryption control sequencer.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package aes_dec_pkg;

  localparam int c_nr   = 14;
  localparam int c_rk_w = 4;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_LOAD     = 4'd1,
    S_ADDK0    = 4'd2,
    S_SHIFT    = 4'd3,
    S_SUB_REQ  = 4'd4,
    S_SUB_WAIT = 4'd5,
    S_ADDK     = 4'd6,
    S_MIX      = 4'd7,
    S_DONE     = 4'd8,
    S_ERR      = 4'd9
  } state_t;

  typedef enum logic [2:0] {
    OP_NOP       = 3'd0,
    OP_LOAD      = 3'd1,
    OP_ADDKEY    = 3'd2,
    OP_INV_SHIFT = 3'd3,
    OP_INV_SUB   = 3'd4,
    OP_INV_MIX   = 3'd5
  } op_t;

endpackage
`default_nettype wire

// File: rtl/aes_seq_wdog.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | aes_seq_wdog                                                               |
// | Counts S-box wait cycles and flags when SUB_TIMEOUT of them have elapsed.  |
// | Used only when AES_SEQ_TIMEOUT_EN is defined.                              |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module aes_seq_wdog
  import aes_dec_pkg::*;
#(
  parameter int SUB_TIMEOUT = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic en_i,
  output logic timeout_o
);

  localparam int                 c_cnt_w = $clog2(SUB_TIMEOUT + 1);
  localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(SUB_TIMEOUT - 1);

  logic [c_cnt_w-1:0] r_cnt;

  // Saturates at the last wait cycle; the sequencer leaves SUB_WAIT there anyway
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (clear_i) begin
      r_cnt <= '0;
    end else if (en_i && (r_cnt != c_last)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign timeout_o = en_i && (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/aes_dec_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | aes_dec_sequencer                                                          |
// | Round sequencer for the AES-256 inverse cipher datapath and S-box engine.  |
// | Optional S-box watchdog: define AES_SEQ_TIMEOUT_EN.                        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module aes_dec_sequencer
  import aes_dec_pkg::*;
#(
  parameter int NR          = c_nr,
  parameter int SUB_TIMEOUT = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic              sub_done_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              sub_start_o,
  output logic [2:0]        sel_o,
  output logic              state_we_o,
  output logic [c_rk_w-1:0] rk_idx_o,
  output logic              err_o
);

  localparam logic [c_rk_w-1:0] c_nr_init = c_rk_w'(NR);

  if ((NR < 1) || (NR >= (1 << c_rk_w)) || (SUB_TIMEOUT < 1)) begin : g_param_check
    $error("aes_dec_sequencer: NR must fit the round-key index and SUB_TIMEOUT must be >= 1");
  end

  state_t            r_state;
  state_t            w_next;
  op_t               w_sel;
  logic              w_we;
  logic              w_sub_start;
  logic              w_done;
  logic              w_abort;
  logic              w_timeout;
  logic [c_rk_w-1:0] r_round;

  assign w_abort = abort_i && (r_state != S_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Round counter doubles as the round-key index; zero-guarded so it never wraps
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_round <= '0;
    end else if (r_state == S_LOAD) begin
      r_round <= c_nr_init;
    end else if (((r_state == S_ADDK0) || (r_state == S_MIX)) && (r_round != '0)) begin
      r_round <= r_round - 1'b1;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_sel       = OP_NOP;
    w_we        = 1'b0;
    w_sub_start = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start_i) w_next = S_LOAD;
      end
      S_LOAD: begin
        w_sel  = OP_LOAD;
        w_we   = 1'b1;
        w_next = S_ADDK0;
      end
      S_ADDK0: begin
        w_sel  = OP_ADDKEY;
        w_we   = 1'b1;
        w_next = S_SHIFT;
      end
      S_SHIFT: begin
        w_sel  = OP_INV_SHIFT;
        w_we   = 1'b1;
        w_next = S_SUB_REQ;
      end
      S_SUB_REQ: begin
        w_sub_start = 1'b1;
        w_next      = S_SUB_WAIT;
      end
      S_SUB_WAIT: begin
        // Engine result is only valid in the done cycle, so the write is gated live
        if (sub_done_i) begin
          w_sel  = OP_INV_SUB;
          w_we   = 1'b1;
          w_next = S_ADDK;
        end else if (w_timeout) begin
          w_next = S_ERR;
        end
      end
      S_ADDK: begin
        w_sel  = OP_ADDKEY;
        w_we   = 1'b1;
        w_next = (r_round == '0) ? S_DONE : S_MIX;
      end
      S_MIX: begin
        w_sel  = OP_INV_MIX;
        w_we   = 1'b1;
        w_next = S_SHIFT;
      end
      S_DONE: begin
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      S_ERR: begin
        w_next = S_ERR;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
    if (w_abort) begin
      w_next      = S_IDLE;
      w_we        = 1'b0;
      w_sub_start = 1'b0;
      w_done      = 1'b0;
    end
  end

  assign busy_o      = (r_state != S_IDLE);
  assign done_o      = w_done;
  assign sub_start_o = w_sub_start;
  assign sel_o       = w_sel;
  assign state_we_o  = w_we;
  assign rk_idx_o    = r_round;

`ifdef AES_SEQ_TIMEOUT_EN
  logic r_err;

  aes_seq_wdog #(
    .SUB_TIMEOUT (SUB_TIMEOUT)
  ) u_wdog (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (r_state == S_SUB_REQ),
    .en_i      (r_state == S_SUB_WAIT),
    .timeout_o (w_timeout)
  );

  // Sticky until the next accepted start
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err <= 1'b0;
    end else if ((r_state == S_IDLE) && start_i) begin
      r_err <= 1'b0;
    end else if (w_next == S_ERR) begin
      r_err <= 1'b1;
    end
  end

  assign err_o = r_err;
`else
  assign w_timeout = 1'b0;
  assign err_o     = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_aes_dec_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_aes_dec_sequencer                                                       |
// | Directed, table-driven bench for aes_dec_sequencer with an S-box model.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_aes_dec_sequencer;
  import aes_dec_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_i;
  logic       abort_i;
  logic       sub_done_i;
  logic       busy_o;
  logic       done_o;
  logic       sub_start_o;
  logic [2:0] sel_o;
  logic       state_we_o;
  logic [3:0] rk_idx_o;
  logic       err_o;

  always #5 clk = ~clk;

  aes_dec_sequencer #(
    .NR          (14),
    .SUB_TIMEOUT (32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .abort_i     (abort_i),
    .sub_done_i  (sub_done_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .sub_start_o (sub_start_o),
    .sel_o       (sel_o),
    .state_we_o  (state_we_o),
    .rk_idx_o    (rk_idx_o),
    .err_o       (err_o)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: tallies datapath writes and handshakes at the falling edge
  int         n_load = 0, n_addk = 0, n_shift = 0, n_sub = 0, n_mix = 0;
  int         n_start = 0, n_done = 0, done_cyc = 0;
  logic [3:0] rk_log [0:1023];

  always @(negedge clk) begin
    if (state_we_o && sel_o == 3'd1) n_load <= n_load + 1;
    if (state_we_o && sel_o == 3'd2) begin
      if (n_addk < 1024) rk_log[n_addk] <= rk_idx_o;
      n_addk <= n_addk + 1;
    end
    if (state_we_o && sel_o == 3'd3) n_shift <= n_shift + 1;
    if (state_we_o && sel_o == 3'd4) n_sub <= n_sub + 1;
    if (state_we_o && sel_o == 3'd5) n_mix <= n_mix + 1;
    if (sub_start_o) n_start <= n_start + 1;
    if (done_o) begin
      n_done   <= n_done + 1;
      done_cyc <= cyc;
    end
  end

  // Inverse S-box engine model: done L cycles after the launch cycle, optional stray done
  int eng_lat  = 1;
  bit eng_spur = 1'b0;
  int eng_cnt  = 0;

  initial begin
    sub_done_i = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      sub_done_i = 1'b0;
      if (eng_cnt > 0) begin
        eng_cnt--;
        if (eng_cnt == 0) sub_done_i = 1'b1;
      end
      if (sub_start_o) begin
        eng_cnt = eng_lat;
        if (eng_spur) sub_done_i = 1'b1;
      end
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic run_op(input int lat, input bit spur, output int t0);
    eng_lat  = lat;
    eng_spur = spur;
    @(posedge clk);
    #1;
    start_i = 1'b1;
    t0      = cyc;
    @(posedge clk);
    #1;
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int base, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #1;
      if (n_done > base) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_sub_starts(input int count, input int budget, output bit ok);
    int seen;
    seen = 0;
    ok   = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #3;
      if (sub_start_o) seen++;
      if (seen == count) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  typedef struct {
    int lat;
    bit spur;
    int exp_dly;
    int exp_subs;
    int exp_mix;
  } vec_t;

  vec_t vecs [4];

  initial begin
    int t0, t1;
    int b_load, b_addk, b_shift, b_sub, b_mix, b_start, b_done;
    bit ok;

    vecs[0] = '{lat: 16, spur: 1'b0, exp_dly: 282, exp_subs: 14, exp_mix: 13};
    vecs[1] = '{lat: 1,  spur: 1'b1, exp_dly: 72,  exp_subs: 14, exp_mix: 13};
    vecs[2] = '{lat: 5,  spur: 1'b1, exp_dly: 128, exp_subs: 14, exp_mix: 13};
    vecs[3] = '{lat: 2,  spur: 1'b0, exp_dly: 86,  exp_subs: 14, exp_mix: 13};

    rst     = 1'b0;
    start_i = 1'b0;
    abort_i = 1'b0;

    // Outputs while reset is held
    #3;
    check("rst_busy",  busy_o,      0);
    check("rst_done",  done_o,      0);
    check("rst_subst", sub_start_o, 0);
    check("rst_sel",   sel_o,       0);
    check("rst_we",    state_we_o,  0);
    check("rst_rk",    rk_idx_o,    0);
    check("rst_err",   err_o,       0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_busy", busy_o, 0);

    // Nominal runs across engine latencies
    for (int v = 0; v < 4; v++) begin
      b_load = n_load; b_addk = n_addk; b_shift = n_shift; b_sub = n_sub;
      b_mix = n_mix; b_start = n_start; b_done = n_done;
      check("idle_before_run", busy_o, 0);
      run_op(vecs[v].lat, vecs[v].spur, t0);
      wait_done(b_done, 400, ok);
      check("done_seen", ok, 1);
      check("done_latency", done_cyc - t0, vecs[v].exp_dly);
      check("sub_start_count", n_start - b_start, vecs[v].exp_subs);
      check("inv_sub_writes", n_sub - b_sub, vecs[v].exp_subs);
      check("inv_shift_writes", n_shift - b_shift, vecs[v].exp_subs);
      check("inv_mix_writes", n_mix - b_mix, vecs[v].exp_mix);
      check("load_writes", n_load - b_load, 1);
      check("addkey_writes", n_addk - b_addk, 15);
      for (int k = 0; k < 15; k++) begin
        check("rk_sequence", rk_log[b_addk + k], 14 - k);
      end
      check("idle_after_done", busy_o, 0);
      repeat (3) @(posedge clk);
      #1;
      check("single_done", n_done - b_done, 1);
    end

    // Abort in round-7 SUB_WAIT, coincident with sub_done_i
    b_sub = n_sub; b_mix = n_mix; b_done = n_done;
    run_op(4, 1'b0, t0);
    wait_sub_starts(7, 400, ok);
    check("abort_reach_r7", ok, 1);
    repeat (4) @(posedge clk);
    #1;
    abort_i = 1'b1;
    @(negedge clk);
    check("abort_we", state_we_o, 0);
    check("abort_done", done_o, 0);
    check("abort_busy_in_cycle", busy_o, 1);
    @(posedge clk);
    #1;
    abort_i = 1'b0;
    check("abort_idle_next", busy_o, 0);
    check("abort_inv_sub_writes", n_sub - b_sub, 6);
    check("abort_mix_writes", n_mix - b_mix, 6);
    repeat (6) @(posedge clk);
    #1;
    check("abort_no_done", n_done - b_done, 0);
    b_done = n_done;
    run_op(4, 1'b0, t0);
    wait_done(b_done, 400, ok);
    check("after_abort_done_seen", ok, 1);
    check("after_abort_latency", done_cyc - t0, 114);

    // Engine never responds
    b_done = n_done;
    run_op(0, 1'b0, t0);
    wait_sub_starts(1, 20, ok);
    check("hang_sub_start", ok, 1);
`ifdef AES_SEQ_TIMEOUT_EN
    repeat (32) @(posedge clk);
    #1;
    check("to_last_wait_err", err_o, 0);
    check("to_last_wait_busy", busy_o, 1);
    @(posedge clk);
    #1;
    check("to_err_set", err_o, 1);
    check("to_err_busy", busy_o, 1);
    repeat (5) @(posedge clk);
    #1;
    check("to_err_hold", err_o, 1);
    check("to_err_hold_busy", busy_o, 1);
    abort_i = 1'b1;
    @(posedge clk);
    #1;
    abort_i = 1'b0;
    check("to_abort_idle", busy_o, 0);
    check("to_err_sticky", err_o, 1);
    repeat (3) @(posedge clk);
    #1;
    check("to_err_sticky_idle", err_o, 1);
    eng_lat = 1;
    start_i = 1'b1;
    t0      = cyc;
    @(negedge clk);
    check("to_err_at_start", err_o, 1);
    @(posedge clk);
    #1;
    start_i = 1'b0;
    check("to_err_cleared", err_o, 0);
    wait_done(b_done, 200, ok);
    check("to_rerun_done", ok, 1);
    check("to_rerun_latency", done_cyc - t0, 72);
`else
    repeat (40) @(posedge clk);
    #1;
    check("hang_still_busy", busy_o, 1);
    check("hang_no_err", err_o, 0);
    check("hang_no_we", state_we_o, 0);
    abort_i = 1'b1;
    @(posedge clk);
    #1;
    abort_i = 1'b0;
    check("hang_abort_idle", busy_o, 0);
    check("hang_no_done", n_done - b_done, 0);
`endif

    // start_i held high: one run, next one begins right after DONE
    repeat (2) @(posedge clk);
    b_done = n_done; b_load = n_load;
    eng_lat = 1; eng_spur = 1'b0;
    @(posedge clk);
    #1;
    start_i = 1'b1;
    t0      = cyc;
    wait_done(b_done, 200, ok);
    check("held_done_seen", ok, 1);
    check("held_done_latency", done_cyc - t0, 72);
    check("held_single_load", n_load - b_load, 1);
    check("held_idle_gap", busy_o, 0);
    @(posedge clk);
    #1;
    check("held_second_load_sel", sel_o, 1);
    check("held_second_load_we", state_we_o, 1);
    start_i = 1'b0;
    wait_done(b_done + 1, 200, ok);
    check("held_second_done", ok, 1);
    check("held_second_latency", done_cyc - t0, 145);

    // Asynchronous reset in the middle of round 3
    repeat (2) @(posedge clk);
    b_done = n_done;
    run_op(5, 1'b0, t0);
    wait_sub_starts(3, 200, ok);
    check("rst_reach_r3", ok, 1);
    check("rst_pre_busy", busy_o, 1);
    #1;
    rst = 1'b0;
    #1;
    check("amid_rst_busy",  busy_o,      0);
    check("amid_rst_done",  done_o,      0);
    check("amid_rst_subst", sub_start_o, 0);
    check("amid_rst_sel",   sel_o,       0);
    check("amid_rst_we",    state_we_o,  0);
    check("amid_rst_rk",    rk_idx_o,    0);
    check("amid_rst_err",   err_o,       0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("after_rst_busy", busy_o, 0);
    check("after_rst_we", state_we_o, 0);
    repeat (8) @(posedge clk);
    check("after_rst_no_done", n_done - b_done, 0);
    run_op(1, 1'b0, t0);
    wait_done(b_done, 200, ok);
    check("after_rst_done_seen", ok, 1);
    check("after_rst_latency", done_cyc - t0, 72);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish, got %0d cycles, expected fewer", cyc);
    $fatal(1, "global timeout");
  end

endmodule
`default_nettype wire
